// File: rtl/rf_arb2_ctrl_if.sv
// Client-side request/grant and read-return bundle for the two-port register-file arbiter.
interface rf_arb2_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  // Handshake: a client raises reqN with weN/addrN/wdataN and holds them stable;
  // the transfer is accepted on the rising edge where reqN && gntN. gntN is
  // combinational and may depend on reqN in the same cycle. rvalidN is a
  // one-cycle strobe qualifying rdataN, which holds until that port's next read.
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
  );
endinterface

// File: rtl/rf_arb2_ctrl.sv
// Round-robin two-client arbiter/sequencer for the 256x16 single-port register file macro.
// Optional post-reset clear sweep is enabled by defining RF_ARB2_INIT_CLEAR_EN.
module rf_arb2_ctrl #(
  parameter int                  DATA_W     = 16,
  parameter int                  RA_W       = 6,
  parameter int                  CA_W       = 2,
  parameter logic [DATA_W-1:0]   INIT_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RST,
  rf_arb2_ctrl_if.slave     cl,
  output logic              NCE,
  output logic              NWRT,
  output logic [RA_W-1:0]   RA,
  output logic [CA_W-1:0]   CA,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DO,
  output logic              dbg_state
);
  localparam int ADDR_W = RA_W + CA_W;

  logic              run;
  logic              last_q;
  logic              acc0;
  logic              acc1;
  logic              gnt0;
  logic              gnt1;
  logic              nce_d;
  logic              nwrt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              rd1_q;
  logic              port1_q;
  logic              rd2_q;
  logic              port2_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

`ifdef RF_ARB2_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign cl.busy = (state_q == ST_INIT);
`else
  typedef enum logic {ST_RUN} state_t;
  state_t state_q;
  logic   unused_init;

  assign state_q     = ST_RUN;
  assign run         = 1'b1;
  assign cl.busy     = 1'b0;
  assign unused_init = ^INIT_VALUE;
`endif

  assign dbg_state = state_q;

  // last_q names the most recently served port; on contention the other one wins.
  assign gnt0 = run & cl.req0 & (~cl.req1 | last_q);
  assign gnt1 = run & cl.req1 & (~cl.req0 | ~last_q);
  assign acc0 = cl.req0 & gnt0;
  assign acc1 = cl.req1 & gnt1;

  assign cl.gnt0    = gnt0;
  assign cl.gnt1    = gnt1;
  assign cl.rvalid0 = rvalid0_q;
  assign cl.rvalid1 = rvalid1_q;
  assign cl.rdata0  = rdata0_q;
  assign cl.rdata1  = rdata1_q;

  // Next macro pin values; address and data hold when the macro is idle.
  always_comb begin
    nce_d  = 1'b1;
    nwrt_d = 1'b1;
    addr_d = {RA, CA};
    din_d  = DIN;
`ifdef RF_ARB2_INIT_CLEAR_EN
    if (!run) begin
      nce_d  = 1'b0;
      nwrt_d = 1'b0;
      addr_d = cnt_q;
      din_d  = INIT_VALUE;
    end else
`endif
    if (acc0) begin
      nce_d  = 1'b0;
      nwrt_d = ~cl.we0;
      addr_d = cl.addr0;
      din_d  = cl.wdata0;
    end else if (acc1) begin
      nce_d  = 1'b0;
      nwrt_d = ~cl.we1;
      addr_d = cl.addr1;
      din_d  = cl.wdata1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      NCE    <= 1'b1;
      NWRT   <= 1'b1;
      RA     <= '0;
      CA     <= '0;
      DIN    <= '0;
      last_q <= 1'b1;
    end else begin
      NCE      <= nce_d;
      NWRT     <= nwrt_d;
      {RA, CA} <= addr_d;
      DIN      <= din_d;
      if (acc0)      last_q <= 1'b0;
      else if (acc1) last_q <= 1'b1;
    end
  end

  // Read tag follows the access: stage 1 while the macro samples, stage 2 while DO is valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd1_q     <= 1'b0;
      port1_q   <= 1'b0;
      rd2_q     <= 1'b0;
      port2_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd1_q     <= (acc0 & ~cl.we0) | (acc1 & ~cl.we1);
      port1_q   <= acc1;
      rd2_q     <= rd1_q;
      port2_q   <= port1_q;
      rvalid0_q <= rd2_q & ~port2_q;
      rvalid1_q <= rd2_q & port2_q;
      if (rd2_q && !port2_q) rdata0_q <= DO;
      if (rd2_q && port2_q)  rdata1_q <= DO;
    end
  end
endmodule

// File: tb/tb_rf_arb2_ctrl.sv
// Randomized self-checking bench for rf_arb2_ctrl with a behavioural macro and a
// transaction-level reference model (memory array plus per-port expected read queues).
module tb_rf_arb2_ctrl;
  localparam logic [15:0] INIT_V = 16'hFFFF;
`ifdef RF_ARB2_INIT_CLEAR_EN
  localparam int SWEEP_AT_RESET = 0;
`else
  localparam int SWEEP_AT_RESET = 256;
`endif

  logic        CLK;
  logic        RST;
  logic        NCE;
  logic        NWRT;
  logic [5:0]  RA;
  logic [1:0]  CA;
  logic [15:0] DIN;
  logic [15:0] DO = '0;
  logic        dbg_state_unused;

  rf_arb2_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  rf_arb2_ctrl #(.INIT_VALUE(INIT_V)) dut (
    .CLK(CLK), .RST(RST), .cl(bus),
    .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .DO(DO),
    .dbg_state(dbg_state_unused)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- behavioural macro ----------------
  function automatic logic [15:0] pat(input int i);
    return 16'hD00D ^ 16'(i * 257);
  endfunction

  logic [15:0] mac_mem [256];
  logic        mac_init = 1'b0;
  always @(posedge CLK) begin
    if (!mac_init) begin
      for (int i = 0; i < 256; i++) mac_mem[i] <= pat(i);
      mac_init <= 1'b1;
    end else if (!NCE) begin
      if (!NWRT) mac_mem[{RA, CA}] <= DIN;
      else       DO <= mac_mem[{RA, CA}];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_port;
  int          sweep_idx;
  int          busy_seen = 0;
  logic        obs_g1;
  logic        last_m;
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          due_q0[$];
  int          due_q1[$];
  logic [15:0] rdata_m0;
  logic [15:0] rdata_m1;
  logic        exp_nce;
  logic        exp_nwrt;
  logic [7:0]  exp_addr;
  logic [15:0] exp_din;
  logic [7:0]  gseq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    due_q0.delete();
    due_q1.delete();
    last_m    = 1'b1;
    rdata_m0  = '0;
    rdata_m1  = '0;
    exp_nce   = 1'b1;
    exp_nwrt  = 1'b1;
    exp_addr  = '0;
    exp_din   = '0;
    sweep_idx = SWEEP_AT_RESET;
  endtask

  // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
  task automatic step();
    logic eg0, eg1, ebusy, ev0, ev1, we;
    logic [7:0]  a;
    logic [15:0] d;
    @(negedge CLK);
    ebusy = (sweep_idx < 256);
    eg0 = !ebusy && bus.req0 && (!bus.req1 || last_m == 1'b1);
    eg1 = !ebusy && bus.req1 && (!bus.req0 || last_m == 1'b0);
    obs_g1 = bus.gnt1;
    if (bus.busy) busy_seen++;
    check("gnt0", 32'(bus.gnt0), 32'(eg0));
    check("gnt1", 32'(bus.gnt1), 32'(eg1));
    check("busy", 32'(bus.busy), 32'(ebusy));
    check("nce",  32'(NCE),  32'(exp_nce));
    check("nwrt", 32'(NWRT), 32'(exp_nwrt));
    check("ra",   32'(RA),   32'(exp_addr[7:2]));
    check("ca",   32'(CA),   32'(exp_addr[1:0]));
    check("din",  32'(DIN),  32'(exp_din));
    ev0 = (due_q0.size() > 0) && (due_q0[0] == cyc);
    ev1 = (due_q1.size() > 0) && (due_q1[0] == cyc);
    check("rvalid0", 32'(bus.rvalid0), 32'(ev0));
    check("rvalid1", 32'(bus.rvalid1), 32'(ev1));
    if (ev0) begin
      void'(due_q0.pop_front());
      rdata_m0 = exp_q0.pop_front();
    end
    if (ev1) begin
      void'(due_q1.pop_front());
      rdata_m1 = exp_q1.pop_front();
    end
    check("rdata0", 32'(bus.rdata0), 32'(rdata_m0));
    check("rdata1", 32'(bus.rdata1), 32'(rdata_m1));

    acc_port = eg0 ? 0 : (eg1 ? 1 : -1);
    if (ebusy) begin
      exp_nce   = 1'b0;
      exp_nwrt  = 1'b0;
      exp_addr  = sweep_idx[7:0];
      exp_din   = INIT_V;
      ref_mem[sweep_idx] = INIT_V;
      sweep_idx++;
    end else if (acc_port >= 0) begin
      we = (acc_port == 0) ? bus.we0    : bus.we1;
      a  = (acc_port == 0) ? bus.addr0  : bus.addr1;
      d  = (acc_port == 0) ? bus.wdata0 : bus.wdata1;
      exp_nce  = 1'b0;
      exp_nwrt = !we;
      exp_addr = a;
      exp_din  = d;
      if (we) ref_mem[a] = d;
      else if (acc_port == 0) begin
        exp_q0.push_back(ref_mem[a]);
        due_q0.push_back(cyc + 3);
      end else begin
        exp_q1.push_back(ref_mem[a]);
        due_q1.push_back(cyc + 3);
      end
      last_m = (acc_port == 1);
    end else begin
      exp_nce  = 1'b1;
      exp_nwrt = 1'b1;
    end
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic rand_txn(input int p);
    logic [7:0] a;
    a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom));
  endtask

  task automatic xfer(input int p, input logic we, input logic [7:0] a, input logic [15:0] d);
    logic got;
    got = 1'b0;
    set_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (acc_port == p) got = 1'b1;
    end
    check("xfer_accept", 32'(got), 32'd1);
    set_port(p, 1'b0, we, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Both clients keep requesting; records which port each accept went to in gseq.
  task automatic hold_both(input int n);
    int k;
    k = 0;
    gseq = '0;
    rand_txn(0);
    rand_txn(1);
    for (int i = 0; i < 400 && k < n; i++) begin
      step();
      if (acc_port >= 0) begin
        gseq[k] = obs_g1;
        k++;
        rand_txn(acc_port);
      end
    end
    check("hold_both_count", 32'(k), 32'(n));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_nce",     32'(NCE),         32'd1);
    check("rst_nwrt",    32'(NWRT),        32'd1);
    check("rst_addr",    32'({RA, CA}),    32'd0);
    check("rst_din",     32'(DIN),         32'd0);
    check("rst_gnt",     32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("rst_rvalid",  32'({bus.rvalid1, bus.rvalid0}), 32'd0);
    check("rst_rdata",   32'({bus.rdata1, bus.rdata0}), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'(SWEEP_AT_RESET == 0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    set_port(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    apply_reset();

`ifdef RF_ARB2_INIT_CLEAR_EN
    // req0 is held through the sweep; grants are checked low every busy cycle.
    xfer(0, 1'b0, 8'h00, 16'h0000);
    check("busy_cycles", 32'(busy_seen), 32'd256);
    xfer(0, 1'b0, 8'h80, 16'h0000);
    xfer(0, 1'b0, 8'hFF, 16'h0000);
    idle(4);
    check("clear_rd_ff", 32'(bus.rdata0), 32'(INIT_V));
`endif

    // Write then read the same word from the other port.
    xfer(0, 1'b1, 8'h3C, 16'hA5A5);
    idle(1);
    xfer(1, 1'b0, 8'h3C, 16'h0000);
    check("issue_ra_0f", 32'(RA), 32'h0F);
    check("issue_ca_0",  32'(CA), 32'h0);
    idle(3);
    check("rdata1_a5a5", 32'(bus.rdata1), 32'hA5A5);

    // Contention: grants alternate starting with port 0.
    hold_both(4);
    check("alt_seq", 32'(gseq[3:0]), 32'b1010);
    idle(4);

    // Back-to-back write/read on port 0.
    xfer(0, 1'b1, 8'h07, 16'h1234);
    xfer(0, 1'b0, 8'h07, 16'h0000);
    idle(3);
    check("rdata0_1234", 32'(bus.rdata0), 32'h1234);

    // Quiet bus.
    idle(12);

    // Reset shortly after a read accept.
    xfer(0, 1'b0, 8'h07, 16'h0000);
    RST = 1'b1;
    #1;
    check("midrst_nce",    32'(NCE),         32'd1);
    check("midrst_rvalid", 32'(bus.rvalid0), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(5);
    hold_both(2);
    check("first_gnt_p0", 32'(gseq[0]), 32'd0);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0 && $urandom_range(0, 1) == 1) rand_txn(0);
      if (!bus.req1 && $urandom_range(0, 1) == 1) rand_txn(1);
      step();
      if (acc_port == 0) bus.req0 = 1'b0;
      if (acc_port == 1) bus.req1 = 1'b0;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    idle(6);
    check("drain0", 32'(due_q0.size()), 32'd0);
    check("drain1", 32'(due_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
